// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: timestamp field layout, field moduli and the
// lap store state type, plus the per-field borrow subtraction helper.
package stopwatch_pkg;

  localparam int FIELD_W  = 7;
  localparam int TIME_W   = 4 * FIELD_W;
  localparam int MSEC_LSB = 0;
  localparam int SEC_LSB  = 7;
  localparam int MIN_LSB  = 14;
  localparam int HOUR_LSB = 21;

  localparam int MSEC_MOD = 100;
  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 100;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    CLEAR   = 2'd2
  } lap_state_t;

  // Returns {borrow_out, field}; a negative raw difference wraps by the field modulus.
  function automatic logic [FIELD_W:0] field_sub(
    input logic [FIELD_W-1:0] a,
    input logic [FIELD_W-1:0] b,
    input logic               borrow_in,
    input logic [FIELD_W:0]   modulus
  );
    logic [FIELD_W:0] raw;
    logic [FIELD_W:0] wrapped;
    raw     = {1'b0, a} - {1'b0, b} - {{FIELD_W{1'b0}}, borrow_in};
    wrapped = raw[FIELD_W] ? (raw + modulus) : raw;
    return {raw[FIELD_W], wrapped[FIELD_W-1:0]};
  endfunction

endpackage

// File: rtl/lap_store_if.sv
// Lap store bus: live timestamp and control pulses from the key logic side,
// selected record and status flags back from the store.
interface lap_store_if #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 28
);
  logic [TS_W-1:0]          timestamp;
  logic                     lap_capture;
  logic                     clear;
  logic                     view_step;
  logic [TS_W-1:0]          view_timestamp;
  logic [$clog2(DEPTH)-1:0] view_index;
  logic [$clog2(DEPTH):0]   lap_count;
  logic                     empty;
  logic                     full;
  logic                     overflow;
  logic                     busy;

  modport master (
    output timestamp, lap_capture, clear, view_step,
    input  view_timestamp, view_index, lap_count, empty, full, overflow, busy
  );

  modport slave (
    input  timestamp, lap_capture, clear, view_step,
    output view_timestamp, view_index, lap_count, empty, full, overflow, busy
  );
endinterface

// File: rtl/time_subtract.sv
// Combinational field-wise borrow subtractor for {hour, minute, second, m_sec}
// timestamps; used by lap_store to turn absolute lap times into splits.
module time_subtract
  import stopwatch_pkg::*;
(
  input  logic [TIME_W-1:0] minuend,
  input  logic [TIME_W-1:0] subtrahend,
  output logic [TIME_W-1:0] diff
);

  logic [FIELD_W:0] msec_r;
  logic [FIELD_W:0] sec_r;
  logic [FIELD_W:0] min_r;
  logic [FIELD_W:0] hour_r;

  // Borrow ripples from m_sec up to hour; hour simply wraps at 100.
  always_comb begin
    msec_r = field_sub(minuend[MSEC_LSB +: FIELD_W], subtrahend[MSEC_LSB +: FIELD_W],
                       1'b0, (FIELD_W+1)'(MSEC_MOD));
    sec_r  = field_sub(minuend[SEC_LSB +: FIELD_W], subtrahend[SEC_LSB +: FIELD_W],
                       msec_r[FIELD_W], (FIELD_W+1)'(SEC_MOD));
    min_r  = field_sub(minuend[MIN_LSB +: FIELD_W], subtrahend[MIN_LSB +: FIELD_W],
                       sec_r[FIELD_W], (FIELD_W+1)'(MIN_MOD));
    hour_r = field_sub(minuend[HOUR_LSB +: FIELD_W], subtrahend[HOUR_LSB +: FIELD_W],
                       min_r[FIELD_W], (FIELD_W+1)'(HOUR_MOD));
    diff   = {hour_r[FIELD_W-1:0], min_r[FIELD_W-1:0], sec_r[FIELD_W-1:0], msec_r[FIELD_W-1:0]};
  end

endmodule

// File: rtl/lap_store.sv
// Circular lap record buffer with a single selectable display record.
// Define LAP_SPLIT_EN to store split times instead of absolute timestamps.
module lap_store
  import stopwatch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 28
)(
  input logic        clock,
  input logic        reset_n,
  lap_store_if.slave bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  lap_state_t      state;
  lap_state_t      state_nxt;
  logic [TS_W-1:0] mem [DEPTH];
  logic [TS_W-1:0] hold;
  logic [TS_W-1:0] view_timestamp;
  logic [IW-1:0]   wr_ptr;
  logic [IW-1:0]   view_index;
  logic [IW-1:0]   clr_idx;
  logic [IW-1:0]   next_view;
  logic [CW-1:0]   view_inc;
  logic [CW-1:0]   lap_count;
  logic            overflow;
  logic            is_full;
  logic            cap_done;

  assign is_full   = (lap_count == CW'(DEPTH));
  assign view_inc  = {1'b0, view_index} + 1'b1;
  assign next_view = (view_inc >= lap_count) ? '0 : view_inc[IW-1:0];

`ifdef LAP_SPLIT_EN
  logic            cap_phase;
  logic [TS_W-1:0] prev_ts;
  logic [TS_W-1:0] split_ts;

  time_subtract u_time_subtract (
    .minuend    (hold),
    .subtrahend (prev_ts),
    .diff       (split_ts)
  );

  // First CAPTURE cycle converts hold into a split; the second one writes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cap_phase <= 1'b0;
      prev_ts   <= '0;
    end else if (state == CAPTURE) begin
      cap_phase <= !cap_phase;
      if (!cap_phase) prev_ts <= hold;
    end else if (state == CLEAR) begin
      prev_ts <= '0;
    end
  end

  assign cap_done = cap_phase;
`else
  assign cap_done = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.clear)                       state_nxt = CLEAR;
        else if (bus.lap_capture && !is_full) state_nxt = CAPTURE;
      end
      CAPTURE: if (cap_done)                  state_nxt = IDLE;
      CLEAR:   if (clr_idx == IW'(DEPTH - 1)) state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  // Pulses are only honoured in IDLE; clear outranks capture outranks view_step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold       <= '0;
      wr_ptr     <= '0;
      view_index <= '0;
      lap_count  <= '0;
      overflow   <= 1'b0;
      clr_idx    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear) begin
            clr_idx <= '0;
          end else if (bus.lap_capture) begin
            if (is_full) overflow <= 1'b1;
            else         hold     <= bus.timestamp;
          end else if (bus.view_step && lap_count != '0) begin
            view_index <= next_view;
          end
        end
        CAPTURE: begin
`ifdef LAP_SPLIT_EN
          if (!cap_phase) hold <= split_ts;
`endif
          if (cap_done) begin
            wr_ptr     <= wr_ptr + 1'b1;
            lap_count  <= lap_count + 1'b1;
            view_index <= wr_ptr;
          end
        end
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '0) begin
            lap_count  <= '0;
            wr_ptr     <= '0;
            view_index <= '0;
            overflow   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (state == CAPTURE && cap_done) mem[wr_ptr]  <= hold;
    else if (state == CLEAR)          mem[clr_idx] <= '0;
  end

  // Slots beyond lap_count are never selected, so only the empty case needs masking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               view_timestamp <= '0;
    else if (lap_count == '0)   view_timestamp <= '0;
    else                        view_timestamp <= mem[view_index];
  end

  assign bus.view_timestamp = view_timestamp;
  assign bus.view_index     = view_index;
  assign bus.lap_count      = lap_count;
  assign bus.empty          = (lap_count == '0);
  assign bus.full           = is_full;
  assign bus.overflow       = overflow;
  assign bus.busy           = (state != IDLE);

endmodule
